// File: rtl/carry_lookahead_adder.sv
// Two-level carry-lookahead adder: 4-bit lookahead groups feeding a group-level
// lookahead unit, with sum, carry-out, overflow and sign registered together.
module carry_lookahead_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow_flag,
  output logic             negative
);

  localparam int NUM_GROUPS = WIDTH / 4;

  logic [WIDTH-1:0]      g;
  logic [WIDTH-1:0]      p;
  logic [WIDTH:0]        c;
  logic [NUM_GROUPS-1:0] grp_g;
  logic [NUM_GROUPS-1:0] grp_p;
  logic [NUM_GROUPS:0]   grp_c;
  logic [WIDTH-1:0]      sum;

  assign g = A & B;
  assign p = A ^ B;

  // Each group resolves its internal carries directly from its own carry-in.
  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
    localparam int L = gi * 4;

    assign c[L]   = grp_c[gi];
    assign c[L+1] = g[L] | (p[L] & grp_c[gi]);
    assign c[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & grp_c[gi]);
    assign c[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                  | (p[L+2] & p[L+1] & p[L] & grp_c[gi]);

    assign grp_g[gi] = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                     | (p[L+3] & p[L+2] & p[L+1] & g[L]);
    assign grp_p[gi] = &p[L+3:L];
  end

  // Group carry j is the OR of every upstream generate (or cin) whose
  // path to j is fully propagating; written as a flat sum of products.
  always_comb begin
    logic term;
    grp_c = '0;
    for (int j = 0; j <= NUM_GROUPS; j++) begin
      for (int k = -1; k < j; k++) begin
        term = (k < 0) ? cin : grp_g[k];
        for (int m = k + 1; m < j; m++) begin
          term = term & grp_p[m];
        end
        grp_c[j] = grp_c[j] | term;
      end
    end
  end

  assign c[WIDTH] = grp_c[NUM_GROUPS];
  assign sum      = p ^ c[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result        <= '0;
      cout          <= 1'b0;
      overflow_flag <= 1'b0;
      negative      <= 1'b0;
    end else begin
      result        <= sum;
      cout          <= c[WIDTH];
      overflow_flag <= c[WIDTH] ^ c[WIDTH-1];
      negative      <= sum[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Directed and random checks of the registered carry-lookahead adder against
// a plain-arithmetic reference model.
module tb_carry_lookahead_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow_flag;
  logic         negative;

  int compared   = 0;
  int mismatched = 0;

  carry_lookahead_adder #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .A             (a_in),
    .B             (b_in),
    .cin           (cin),
    .result        (result),
    .cout          (cout),
    .overflow_flag (overflow_flag),
    .negative      (negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one vector, clock it in, and compare against the model one cycle later.
  task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic rst);
    logic [W:0]   full;
    logic [W-1:0] e_res;
    logic         e_cout, e_ovf, e_neg;
    a_in  = a;
    b_in  = b;
    cin   = ci;
    rst_n = rst;
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e_res  = full[W-1:0];
    e_cout = full[W];
    e_ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    e_neg  = full[W-1];
    if (!rst) begin
      e_res = '0; e_cout = 1'b0; e_ovf = 1'b0; e_neg = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".result"}, result, e_res);
    chk({tag, ".cout"}, {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, e_cout});
    chk({tag, ".ovf"}, {{(W-1){1'b0}}, overflow_flag}, {{(W-1){1'b0}}, e_ovf});
    chk({tag, ".neg"}, {{(W-1){1'b0}}, negative}, {{(W-1){1'b0}}, e_neg});
  endtask

  initial begin
    rst_n = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    @(negedge clk);

    step("rst_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    step("rst_first", 16'h0003, 16'h0004, 1'b1, 1'b1);
    step("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    step("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    step("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b1);
    step("plain", 16'h1234, 16'h4321, 1'b1, 1'b1);
    step("ones_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    step("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    step("grp_chain", 16'h0FFF, 16'h0001, 1'b0, 1'b1);
    step("mid_load", 16'h5555, 16'h2AAA, 1'b1, 1'b1);
    step("mid_rst", 16'h7000, 16'h1000, 1'b0, 1'b0);
    step("post_rst", 16'hABCD, 16'h1111, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      step("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/carry_lookahead_adder.md
CARRY_LOOKAHEAD_ADDER -- requirements
Module: carry_lookahead_adder

Interface
- REQ-001: Parameter WIDTH, default 16: operand/result width; SHALL be a positive multiple of 4; all values below assume 16.
- REQ-002: clk, input, 1: single clock; all state SHALL update on the rising edge.
- REQ-003: rst_n, input, 1: reset, synchronous, active-low.
- REQ-004: A, input, WIDTH: operand A, two's complement.
- REQ-005: B, input, WIDTH: operand B, two's complement.
- REQ-006: cin, input, 1: carry-in to bit 0.
- REQ-007: result, output, WIDTH: registered sum bits [WIDTH-1:0].
- REQ-008: cout, output, 1: registered carry-out of the MSB.
- REQ-009: overflow_flag, output, 1: registered signed-overflow flag.
- REQ-010: negative, output, 1: registered sign flag of result.

Function
- REQ-011: Sum SHALL be computed as {cout, result} = A + B + cin, modulo 2^(WIDTH+1).
- REQ-012: Carries SHALL use carry-lookahead logic, not ripple:
  - per-bit g = A&B, p = A^B;
  - 4-bit groups with internal lookahead carries c[i+1] = g[i] | p[i]&c[i], expanded;
  - group generate G and group propagate P per group;
  - second-level lookahead unit producing each group carry-in from G/P and cin.
- REQ-013: Sum bit i SHALL be p[i] ^ c[i].
- REQ-014: overflow_flag SHALL be 1 iff A[MSB]==B[MSB] and sum[MSB]!=A[MSB]. Equivalent form: carry into MSB XOR carry out of MSB.
- REQ-015: negative SHALL equal sum[MSB], regardless of overflow.
- REQ-016: The adder core SHALL be purely combinational. A, B and cin SHALL be sampled on every rising edge with no enable or handshake.
- REQ-017: All four outputs SHALL register together, with a latency of exactly 1 cycle. Outputs SHALL reflect the inputs sampled at the previous edge.
- REQ-018: Throughput SHALL be one addition per cycle. Back-to-back operand changes SHALL each produce their own result on consecutive cycles.
- REQ-019: Boundary cases SHALL need no special handling; they fall out of REQ-011/014/015:
  - all-ones + cin=1: result 0, cout 1;
  - 0x8000 + 0x8000: overflow.
- REQ-020: The block SHALL contain no X-generating or latch logic. All outputs SHALL be driven on every cycle.

Reset
- REQ-021: While rst_n is 0 at a rising edge, result, cout, overflow_flag and negative SHALL all load 0.
- REQ-022: Reset SHALL take precedence over new operands. The first edge with rst_n=1 SHALL register the sum of the inputs present at that edge.
- REQ-023: Reset asserted mid-stream SHALL discard the in-flight result. Outputs SHALL be 0 on the cycle after that edge.

Verification
- REQ-024: rst_n=0 with A=0xFFFF, B=0xFFFF, cin=1 -> after edge: result=0x0000, cout=0, overflow_flag=0, negative=0.
- REQ-025: A=0x7FFF, B=0x0001, cin=0 -> next cycle: result=0x8000, cout=0, overflow_flag=1, negative=1.
- REQ-026: A=0xFFFF, B=0x0001, cin=0 -> result=0x0000, cout=1, overflow_flag=0, negative=0.
- REQ-027: A=0x8000, B=0x8000, cin=0 -> result=0x0000, cout=1, overflow_flag=1, negative=0.
- REQ-028: A=0x1234, B=0x4321, cin=1 -> result=0x5556, cout=0, overflow_flag=0, negative=0.
- REQ-029: Random 1000 vectors, operands changed every cycle -> each output matches the reference model of REQ-011/014/015 exactly one cycle later.
